axis_width_packer: RTL and testbench



---
 rtl/axis_width_packer.sv | 98 +++++++++
 tb/tb_axis_width_packer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_width_packer.sv
// axis_width_packer: packs RATIO narrow stream beats into one wide word
// (first beat in lane 0); s_axis_last closes a partial word early.
// Ports: clk, reset (sync, active-high); s_axis_valid/data/last/ready
// narrow slave; m_axis_data/valid/last/ready wide master; m_axis_keep
// per-lane mask only when AXIS_PACKER_KEEP_EN is defined.
module axis_width_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int RATIO      = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        s_axis_valid,
  input  logic [DATA_WIDTH-1:0]       s_axis_data,
  input  logic                        s_axis_last,
  output logic                        s_axis_ready,
  output logic [DATA_WIDTH*RATIO-1:0] m_axis_data,
  output logic                        m_axis_valid,
  output logic                        m_axis_last,
  input  logic                        m_axis_ready
`ifdef AXIS_PACKER_KEEP_EN
  ,
  output logic [RATIO-1:0]            m_axis_keep
`endif
);

  localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(RATIO - 1);

  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] acc [RATIO-1];

  logic in_fire;
  logic out_fire;
  logic done;
  logic [DATA_WIDTH*RATIO-1:0] word;

  assign s_axis_ready = !m_axis_valid || m_axis_ready;
  assign in_fire      = s_axis_valid && s_axis_ready;
  assign out_fire     = m_axis_valid && m_axis_ready;
  assign done         = (cnt == CNT_MAX) || s_axis_last;

  // Lanes above cnt stay zero so stale acc contents never leak out.
  always_comb begin
    word = '0;
    for (int k = 0; k < RATIO - 1; k++) begin
      if (CW'(k) < cnt)
        word[k*DATA_WIDTH +: DATA_WIDTH] = acc[k];
    end
    word[cnt*DATA_WIDTH +: DATA_WIDTH] = s_axis_data;
  end

`ifdef AXIS_PACKER_KEEP_EN
  logic [RATIO-1:0] keep;

  always_comb begin
    keep = '0;
    for (int k = 0; k < RATIO; k++)
      keep[k] = (CW'(k) <= cnt);
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt          <= '0;
      m_axis_data  <= '0;
      m_axis_valid <= 1'b0;
      m_axis_last  <= 1'b0;
      for (int k = 0; k < RATIO - 1; k++)
        acc[k] <= '0;
`ifdef AXIS_PACKER_KEEP_EN
      m_axis_keep  <= '0;
`endif
    end else begin
      if (in_fire && !done) begin
        for (int k = 0; k < RATIO - 1; k++) begin
          if (CW'(k) == cnt)
            acc[k] <= s_axis_data;
        end
        cnt <= cnt + 1'b1;
      end
      // A completing beat wins over the drain so back-to-back
      // words leave no bubble.
      if (in_fire && done) begin
        m_axis_data  <= word;
        m_axis_valid <= 1'b1;
        m_axis_last  <= s_axis_last;
        cnt          <= '0;
`ifdef AXIS_PACKER_KEEP_EN
        m_axis_keep  <= keep;
`endif
      end else if (out_fire) begin
        m_axis_valid <= 1'b0;
        m_axis_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axis_width_packer.sv
// tb_axis_width_packer: randomized scoreboard bench for axis_width_packer.
// Model packs accepted beats into words; a monitor pops on transfers.
module tb_axis_width_packer;

  localparam int DW = 8;
  localparam int R  = 4;
  localparam int W  = DW * R;

  logic          clk = 1'b0;
  logic          reset;
  logic          s_axis_valid;
  logic [DW-1:0] s_axis_data;
  logic          s_axis_last;
  logic          s_axis_ready;
  logic [W-1:0]  m_axis_data;
  logic          m_axis_valid;
  logic          m_axis_last;
  logic          m_axis_ready;
`ifdef AXIS_PACKER_KEEP_EN
  logic [R-1:0]  m_axis_keep;
`endif

  axis_width_packer #(.DATA_WIDTH(DW), .RATIO(R)) dut (
    .clk          (clk),
    .reset        (reset),
    .s_axis_valid (s_axis_valid),
    .s_axis_data  (s_axis_data),
    .s_axis_last  (s_axis_last),
    .s_axis_ready (s_axis_ready),
    .m_axis_data  (m_axis_data),
    .m_axis_valid (m_axis_valid),
    .m_axis_last  (m_axis_last),
    .m_axis_ready (m_axis_ready)
`ifdef AXIS_PACKER_KEEP_EN
    ,
    .m_axis_keep  (m_axis_keep)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    logic         last;
    logic [R-1:0] keep;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] part[$];

  int total = 0;
  int bad   = 0;
  int rmode = 0;
  logic chk_lat = 1'b0;
  logic [W-1:0] last_word = '0;
  int words_seen = 0;

  task automatic chk(input logic ok, input string name,
                     input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_beat(input logic [DW-1:0] d, input logic l);
    exp_t e;
    part.push_back(d);
    if (part.size() == R || l) begin
      e.data = '0;
      for (int i = 0; i < part.size(); i++)
        e.data = e.data | (W'(part[i]) << (i * DW));
      e.last = l;
      e.keep = R'((1 << part.size()) - 1);
      sb.push_back(e);
      part.delete();
      chk_lat = 1'b1;
    end
  endtask

  task automatic tick(input logic v, input logic [DW-1:0] d,
                      input logic l, output logic a);
    @(negedge clk);
    s_axis_valid = v;
    s_axis_data  = d;
    s_axis_last  = l;
    case (rmode)
      0:       m_axis_ready = 1'b1;
      1:       m_axis_ready = 1'b0;
      default: m_axis_ready = 1'($urandom_range(0, 1));
    endcase
    #1;
    if (chk_lat) begin
      chk(m_axis_valid == 1'b1, "latency", 64'(m_axis_valid), 64'd1);
      chk_lat = 1'b0;
    end
    chk(s_axis_ready == (!m_axis_valid || m_axis_ready), "ready_eq",
        64'(s_axis_ready), 64'(!m_axis_valid || m_axis_ready));
    a = v && s_axis_ready;
    if (a) model_beat(d, l);
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) tick(1'b0, '0, 1'b0, a);
  endtask

  task automatic send(input logic [DW-1:0] d, input logic l);
    logic a;
    int   tries;
    a = 1'b0;
    tries = 0;
    while (!a && tries < 200) begin
      tick(1'b1, d, l, a);
      tries++;
    end
    if (!a) chk(1'b0, "send_timeout", 64'(tries), 64'd200);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    s_axis_valid = 1'b0;
    s_axis_last  = 1'b0;
    sb.delete();
    part.delete();
    chk_lat = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk(m_axis_valid == 1'b0, "rst_valid", 64'(m_axis_valid), 64'd0);
    chk(m_axis_last == 1'b0, "rst_last", 64'(m_axis_last), 64'd0);
    chk(m_axis_data == '0, "rst_data", 64'(m_axis_data), 64'd0);
    chk(s_axis_ready == 1'b1, "rst_ready", 64'(s_axis_ready), 64'd1);
`ifdef AXIS_PACKER_KEEP_EN
    chk(m_axis_keep == '0, "rst_keep", 64'(m_axis_keep), 64'd0);
`endif
  endtask

  // Monitor: checks AXI stability and pops the scoreboard on transfers.
  initial begin
    logic         have_prev;
    logic         p_stall;
    logic [W-1:0] p_data;
    logic         p_last;
    exp_t         e;
    have_prev = 1'b0;
    p_stall = 1'b0;
    p_data = '0;
    p_last = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        have_prev = 1'b0;
      end else begin
        if (have_prev && p_stall) begin
          chk(m_axis_valid == 1'b1, "hold_valid", 64'(m_axis_valid), 64'd1);
          chk(m_axis_data == p_data, "hold_data",
              64'(m_axis_data), 64'(p_data));
          chk(m_axis_last == p_last, "hold_last",
              64'(m_axis_last), 64'(p_last));
        end
        if (m_axis_valid && m_axis_ready) begin
          if (sb.size() == 0) begin
            chk(1'b0, "unexpected_word", 64'(m_axis_data), 64'd0);
          end else begin
            e = sb.pop_front();
            chk(m_axis_data == e.data, "word_data",
                64'(m_axis_data), 64'(e.data));
            chk(m_axis_last == e.last, "word_last",
                64'(m_axis_last), 64'(e.last));
`ifdef AXIS_PACKER_KEEP_EN
            chk(m_axis_keep == e.keep, "word_keep",
                64'(m_axis_keep), 64'(e.keep));
`endif
          end
          last_word = m_axis_data;
          words_seen++;
        end
        have_prev = 1'b1;
        p_stall = m_axis_valid && !m_axis_ready;
        p_data  = m_axis_data;
        p_last  = m_axis_last;
      end
    end
  end

  initial begin
    logic a;
    int   n0;
    reset = 1'b1;
    s_axis_valid = 1'b0;
    s_axis_data  = '0;
    s_axis_last  = 1'b0;
    m_axis_ready = 1'b1;
    do_reset();

    // Continuous 0x01..0x08 -> two full words.
    rmode = 0;
    n0 = words_seen;
    for (int i = 1; i <= 8; i++) send(DW'(i), 1'b0);
    idle(3);
    chk(words_seen - n0 == 2, "two_words", 64'(words_seen - n0), 64'd2);
    chk(last_word == 32'h08070605, "word2", 64'(last_word),
        64'h08070605);

    // Short word closed by last.
    send(8'hA1, 1'b0);
    send(8'hA2, 1'b1);
    idle(3);
    chk(last_word == 32'h0000A2A1, "short_word", 64'(last_word),
        64'h0000A2A1);

    // Stall a full word for 5 cycles, then release.
    rmode = 1;
    for (int i = 1; i <= 4; i++) send(DW'(i), 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 8'h05, 1'b0, a);
      chk(a == 1'b0, "stall_block", 64'(a), 64'd0);
      chk(m_axis_data == 32'h04030201, "stall_data",
          64'(m_axis_data), 64'h04030201);
    end
    rmode = 0;
    for (int i = 5; i <= 8; i++) send(DW'(i), 1'b0);
    idle(3);
    chk(last_word == 32'h08070605, "after_stall", 64'(last_word),
        64'h08070605);

    // Back-to-back single-beat words: valid must never drop.
    for (int i = 0; i < 4; i++) send(8'hC0 + DW'(i), 1'b1);
    idle(3);

    // Reset mid-word discards the partial word.
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    do_reset();
    for (int i = 3; i <= 6; i++) send(DW'(8'h30 + i), 1'b0);
    idle(3);
    chk(last_word == 32'h36353433, "post_reset", 64'(last_word),
        64'h36353433);

    // Random throttling on both sides.
    rmode = 2;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      send(DW'($urandom_range(0, 255)), $urandom_range(0, 5) == 0);
    end
    send(8'hEE, 1'b1);
    rmode = 0;
    idle(10);
    chk(sb.size() == 0, "drain", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
